// File: rtl/compare_mon_pkg.sv
// compare_mon_pkg: state/class encodings and run-counter width for the hysteresis monitor
package compare_mon_pkg;
  typedef enum logic [1:0] {ST_INIT = 2'b00, ST_BELOW = 2'b01, ST_AT = 2'b10, ST_ABOVE = 2'b11} state_t;
  typedef enum logic [1:0] {CLS_NONE = 2'b00, CLS_BELOW = 2'b01, CLS_AT = 2'b10, CLS_ABOVE = 2'b11} cls_t;
  localparam int RUN_W = 4;
  function automatic state_t cls2state(input cls_t c);
    return state_t'(c);
  endfunction
endpackage

// File: rtl/compare_debounce_cnt.sv
// compare_debounce_cnt: candidate/run tracker raising confirm on the CONFIRM_CNT-th agreeing sample
module compare_debounce_cnt
  import compare_mon_pkg::*;
#(
  parameter int CONFIRM_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       eval,
  input  logic       match,
  input  logic [1:0] cls,
  output logic       confirm
);
  cls_t cand;
  logic [RUN_W-1:0] run, hit;
  always_comb begin
    hit = (cls_t'(cls) == cand) ? run + 1'b1 : RUN_W'(1);
    confirm = eval && !match && hit == RUN_W'(CONFIRM_CNT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cand <= CLS_NONE;
      run <= '0;
    end else if (clear || (eval && (match || confirm))) begin
      cand <= CLS_NONE;
      run <= '0;
    end else if (eval) begin
      cand <= cls_t'(cls);
      run <= hit;
    end
endmodule

// File: rtl/compare_hysteresis_monitor.sv
// compare_hysteresis_monitor: registered comparator stage with debounced BELOW/AT/ABOVE tracking.
// Define COMPARE_MON_STATS_EN to build the saturating ABOVE-entry counter; otherwise event_cnt is 0.
module compare_hysteresis_monitor
  import compare_mon_pkg::*;
#(
  parameter int CONFIRM_CNT = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  input  logic [3:0]       thr,
  input  logic             clear,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [1:0]       state_out,
  output logic             alarm,
  output logic [CNT_W-1:0] event_cnt,
  output logic             err
);
  state_t state, state_nxt;
  cls_t cls;
  logic s1_valid, accept, onehot, eval, confirm, enter_above;
  assign in_ready = !clear;
  assign accept = in_valid && in_ready;
  assign state_out = state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      cmp_a <= '0;
      cmp_b <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        cmp_a <= in_data;
        cmp_b <= thr;
      end
    end
  always_comb begin
    onehot = (2'(cmp_gt) + 2'(cmp_lt) + 2'(cmp_eq)) == 2'd1;
    cls = cmp_gt ? CLS_ABOVE : cmp_lt ? CLS_BELOW : CLS_AT;
    eval = s1_valid && onehot && !clear;
    state_nxt = clear ? ST_INIT : (eval && (state == ST_INIT || confirm)) ? cls2state(cls) : state;
    enter_above = state_nxt == ST_ABOVE && state != ST_ABOVE;
  end
  compare_debounce_cnt #(.CONFIRM_CNT(CONFIRM_CNT)) u_db (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .eval(eval && state != ST_INIT),
    .match(cls2state(cls) == state),
    .cls(cls),
    .confirm(confirm)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_INIT;
      alarm <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      alarm <= enter_above;
      err <= !clear && (err || (s1_valid && !onehot));
    end
`ifdef COMPARE_MON_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) event_cnt <= '0;
    else if (clear) event_cnt <= '0;
    else if (enter_above && !(&event_cnt)) event_cnt <= event_cnt + 1'b1;
`else
  assign event_cnt = '0;
`endif
endmodule
